// File: rtl/nibble_packer.sv
// Assembles up to four tagged nibbles per cycle into two 32-bit staging words (A, B).
// Each word is handed downstream through valid/ready once all eight positions are filled.
module nibble_packer (
    input  logic        CLK,
    input  logic        RESET_L,
    input  logic [15:0] NIBBLE_IN,
    input  logic [11:0] POS_IN,
    input  logic [3:0]  SEL_IN,
    input  logic [3:0]  VALID_IN,
    output logic        IN_READY,
    output logic [31:0] DATA_A,
    output logic [31:0] DATA_B,
    output logic [7:0]  MASK_A,
    output logic [7:0]  MASK_B,
    output logic        VALID_A,
    output logic        VALID_B,
    input  logic        READY_A,
    input  logic        READY_B,
    output logic        COLLISION
);

    localparam int unsigned LANES  = 4;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned POS_W  = 3;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned NPOS   = 8;
    localparam int unsigned NWORDS = 2;

    typedef enum logic {
        FILLING = 1'b0,
        PENDING = 1'b1
    } word_state_e;

    word_state_e                          state_q [NWORDS];
    word_state_e                          state_d [NWORDS];
    logic [NWORDS-1:0][WORD_W-1:0]        data_q, data_d;
    logic [NWORDS-1:0][NPOS-1:0]          mask_q, mask_d;
    logic                                 collision_q, collision_d;
    logic [NWORDS-1:0]                    ready_c;

    assign ready_c  = {READY_B, READY_A};
    assign IN_READY = (state_q[0] == FILLING) && (state_q[1] == FILLING);

    // State register: everything clears immediately on reset, dropping any pending word.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            for (int w = 0; w < NWORDS; w++) begin
                state_q[w] <= FILLING;
            end
            data_q      <= '0;
            mask_q      <= '0;
            collision_q <= 1'b0;
        end else begin
            for (int w = 0; w < NWORDS; w++) begin
                state_q[w] <= state_d[w];
            end
            data_q      <= data_d;
            mask_q      <= mask_d;
            collision_q <= collision_d;
        end
    end

    // Lane writes in ascending order so the highest lane wins a same-position conflict.
    always_comb begin
        data_d      = data_q;
        mask_d      = mask_q;
        collision_d = 1'b0;
        for (int w = 0; w < NWORDS; w++) begin
            state_d[w] = state_q[w];
        end

        if (IN_READY) begin
            for (int i = 0; i < LANES; i++) begin
                if (VALID_IN[i]) begin
                    data_d[SEL_IN[i]][{POS_IN[POS_W*i +: POS_W], 2'b00} +: NIB_W] =
                        NIBBLE_IN[NIB_W*i +: NIB_W];
                    mask_d[SEL_IN[i]][POS_IN[POS_W*i +: POS_W]] = 1'b1;
                    for (int j = i + 1; j < LANES; j++) begin
                        if (VALID_IN[j] && (SEL_IN[j] == SEL_IN[i]) &&
                            (POS_IN[POS_W*j +: POS_W] == POS_IN[POS_W*i +: POS_W])) begin
                            collision_d = 1'b1;
                        end
                    end
                end
            end
        end

        // Per-word completion and handoff; mask clears on handoff, data is left stale.
        for (int w = 0; w < NWORDS; w++) begin
            case (state_q[w])
                FILLING: begin
                    if (mask_d[w] == {NPOS{1'b1}}) begin
                        state_d[w] = PENDING;
                    end
                end
                PENDING: begin
                    if (ready_c[w]) begin
                        state_d[w] = FILLING;
                        mask_d[w]  = '0;
                    end
                end
                default: state_d[w] = FILLING;
            endcase
        end
    end

    assign DATA_A    = data_q[0];
    assign DATA_B    = data_q[1];
    assign MASK_A    = mask_q[0];
    assign MASK_B    = mask_q[1];
    assign VALID_A   = (state_q[0] == PENDING);
    assign VALID_B   = (state_q[1] == PENDING);
    assign COLLISION = collision_q;

endmodule

// File: tb/tb_nibble_packer.sv
// Directed self-checking bench for nibble_packer with hand-computed expectations.
module tb_nibble_packer;

    logic        CLK = 1'b0;
    logic        RESET_L;
    logic [15:0] NIBBLE_IN;
    logic [11:0] POS_IN;
    logic [3:0]  SEL_IN;
    logic [3:0]  VALID_IN;
    logic        IN_READY;
    logic [31:0] DATA_A, DATA_B;
    logic [7:0]  MASK_A, MASK_B;
    logic        VALID_A, VALID_B;
    logic        READY_A, READY_B;
    logic        COLLISION;

    int n_checks = 0;
    int n_errors = 0;

    nibble_packer dut (
        .CLK       (CLK),
        .RESET_L   (RESET_L),
        .NIBBLE_IN (NIBBLE_IN),
        .POS_IN    (POS_IN),
        .SEL_IN    (SEL_IN),
        .VALID_IN  (VALID_IN),
        .IN_READY  (IN_READY),
        .DATA_A    (DATA_A),
        .DATA_B    (DATA_B),
        .MASK_A    (MASK_A),
        .MASK_B    (MASK_B),
        .VALID_A   (VALID_A),
        .VALID_B   (VALID_B),
        .READY_A   (READY_A),
        .READY_B   (READY_B),
        .COLLISION (COLLISION)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET_L   = 1'b1;
        NIBBLE_IN = '0;
        POS_IN    = '0;
        SEL_IN    = '0;
        VALID_IN  = '0;
        READY_A   = 1'b0;
        READY_B   = 1'b0;

        // Asynchronous reset mid-cycle
        #3 RESET_L = 1'b0;
        #1;
        check("rst_data_a", DATA_A, 32'h0);
        check("rst_data_b", DATA_B, 32'h0);
        check("rst_masks", 32'({MASK_B, MASK_A}), 32'h0);
        check("rst_valids", 32'({VALID_B, VALID_A}), 32'h0);
        check("rst_collision", 32'(COLLISION), 32'h0);
        cycle();
        RESET_L = 1'b1;
        #1;
        check("rst_in_ready", 32'(IN_READY), 32'h1);

        // Fill A in two cycles
        NIBBLE_IN = 16'h4321;
        POS_IN    = {3'd3, 3'd2, 3'd1, 3'd0};
        SEL_IN    = 4'h0;
        VALID_IN  = 4'hF;
        cycle();
        check("fill1_data_a", DATA_A, 32'h0000_4321);
        check("fill1_mask_a", 32'(MASK_A), 32'h0F);
        check("fill1_valid_a", 32'(VALID_A), 32'h0);
        NIBBLE_IN = 16'h8765;
        POS_IN    = {3'd7, 3'd6, 3'd5, 3'd4};
        cycle();
        check("fill2_data_a", DATA_A, 32'h8765_4321);
        check("fill2_mask_a", 32'(MASK_A), 32'hFF);
        check("fill2_valid_a", 32'(VALID_A), 32'h1);
        check("fill2_in_ready", 32'(IN_READY), 32'h0);

        // Backpressure: writes to B must be ignored while A pends
        NIBBLE_IN = 16'hFFFF;
        POS_IN    = {3'd3, 3'd2, 3'd1, 3'd0};
        SEL_IN    = 4'hF;
        VALID_IN  = 4'hF;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("bp_in_ready", 32'(IN_READY), 32'h0);
            check("bp_data_a", DATA_A, 32'h8765_4321);
            check("bp_mask_b", 32'(MASK_B), 32'h0);
            check("bp_valid_a", 32'(VALID_A), 32'h1);
        end

        // Handshake A
        VALID_IN = 4'h0;
        READY_A  = 1'b1;
        #1;
        check("hs_in_ready_during", 32'(IN_READY), 32'h0);
        cycle();
        READY_A = 1'b0;
        check("hs_valid_a", 32'(VALID_A), 32'h0);
        check("hs_mask_a", 32'(MASK_A), 32'h0);
        check("hs_data_a_stale", DATA_A, 32'h8765_4321);
        check("hs_in_ready", 32'(IN_READY), 32'h1);

        // Collision: lanes 1 and 3 to A pos 2, lane 3 wins
        NIBBLE_IN = 16'h50A0;
        POS_IN    = {3'd2, 3'd0, 3'd2, 3'd0};
        SEL_IN    = 4'h0;
        VALID_IN  = 4'b1010;
        cycle();
        check("col_data_a", DATA_A, 32'h8765_4521);
        check("col_mask_a", 32'(MASK_A), 32'h04);
        check("col_pulse", 32'(COLLISION), 32'h1);

        // Same position, different words: both write, no collision
        NIBBLE_IN = 16'h0096;
        POS_IN    = '0;
        SEL_IN    = 4'b0010;
        VALID_IN  = 4'b0011;
        cycle();
        check("col_cleared", 32'(COLLISION), 32'h0);
        check("split_mask_a", 32'(MASK_A), 32'h05);
        check("split_mask_b", 32'(MASK_B), 32'h01);
        check("split_data_a", DATA_A, 32'h8765_4526);
        check("split_data_b", DATA_B, 32'h0000_0009);

        // Rewrite of a filled position overwrites silently
        NIBBLE_IN = 16'h000C;
        SEL_IN    = 4'h0;
        VALID_IN  = 4'b0001;
        cycle();
        check("rewrite_data_a", DATA_A, 32'h8765_452C);
        check("rewrite_mask_a", 32'(MASK_A), 32'h05);
        check("rewrite_collision", 32'(COLLISION), 32'h0);

        // Reset mid-fill clears state immediately
        VALID_IN = 4'h0;
        RESET_L  = 1'b0;
        #1;
        check("rstfill_data_a", DATA_A, 32'h0);
        check("rstfill_mask_b", 32'(MASK_B), 32'h0);
        #2 RESET_L = 1'b1;
        cycle();

        // Dual completion: lanes 0,2 -> A, lanes 1,3 -> B
        SEL_IN   = 4'b1010;
        VALID_IN = 4'hF;
        for (int c = 0; c < 4; c++) begin
            NIBBLE_IN = {4'(14 - 2*c), 4'(2*c + 2), 4'(15 - 2*c), 4'(2*c + 1)};
            POS_IN    = {3'(2*c + 1), 3'(2*c + 1), 3'(2*c), 3'(2*c)};
            cycle();
            if (c < 3) begin
                check("dual_valids_early", 32'({VALID_B, VALID_A}), 32'h0);
            end
        end
        VALID_IN = 4'h0;
        check("dual_valids", 32'({VALID_B, VALID_A}), 32'h3);
        check("dual_data_a", DATA_A, 32'h8765_4321);
        check("dual_data_b", DATA_B, 32'h89AB_CDEF);

        // Hand off B only
        READY_B = 1'b1;
        cycle();
        READY_B = 1'b0;
        check("hsb_valids", 32'({VALID_B, VALID_A}), 32'h1);
        check("hsb_mask_b", 32'(MASK_B), 32'h0);
        check("hsb_data_b_stale", DATA_B, 32'h89AB_CDEF);
        check("hsb_in_ready", 32'(IN_READY), 32'h0);

        // Reset while A pending drops the word
        RESET_L = 1'b0;
        #1;
        check("rstpend_valid_a", 32'(VALID_A), 32'h0);
        check("rstpend_data_a", DATA_A, 32'h0);
        #2 RESET_L = 1'b1;
        cycle();
        check("rstpend_in_ready", 32'(IN_READY), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
        $finish;
    end

endmodule
